// File: rtl/pipe_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_if
//   Handshake bundle between the pipeline datapath and its hazard controller.
//   master : the datapath; it drives the ID/EX/MEM status and reads back the
//            stage enables, flushes, forwarding selects and counters.
//   slave  : pipe_ctrl itself.
//   Signals:
//     id_rs, id_rt          source registers of the instruction in ID
//     id_use_rs, id_use_rt  the ID instruction really reads rs / rt
//     id_wr_en, id_wr_addr  register write of the ID instruction
//     id_mem_rd             the ID instruction is a load
//     ex_br_taken           branch/jump resolved taken in EX this cycle
//     mem_busy              data memory not ready, whole pipe must hold
//     pc_en..mem_en         per-stage register load enables
//     if_flush, id_flush    load NOP/bubble into IF/ID or ID/EX
//     fwd_a, fwd_b          00 regfile, 01 EX, 10 MEM, 11 WB
//     stall_cnt, flush_cnt  performance counters (0 unless enabled)
// -----------------------------------------------------------------------------
interface pipe_ctrl_if;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_use_rs;
  logic        id_use_rt;
  logic        id_wr_en;
  logic [4:0]  id_wr_addr;
  logic        id_mem_rd;
  logic        ex_br_taken;
  logic        mem_busy;
  logic        pc_en;
  logic        if_en;
  logic        id_en;
  logic        ex_en;
  logic        mem_en;
  logic        if_flush;
  logic        id_flush;
  logic [1:0]  fwd_a;
  logic [1:0]  fwd_b;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, id_wr_en, id_wr_addr,
           id_mem_rd, ex_br_taken, mem_busy,
    input  pc_en, if_en, id_en, ex_en, mem_en, if_flush, id_flush,
           fwd_a, fwd_b, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, id_wr_en, id_wr_addr,
           id_mem_rd, ex_br_taken, mem_busy,
    output pc_en, if_en, id_en, ex_en, mem_en, if_flush, id_flush,
           fwd_a, fwd_b, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
//   Hazard / forwarding controller for a 5-stage in-order pipeline.
//   Tracks {wr_en, wr_addr, mem_rd} of the instructions in EX, MEM and WB and
//   decides, with zero-cycle latency, the stage enables, flushes and operand
//   forwarding selects. Decision priority: mem_busy > branch > load-use.
//   Ports:
//     clk  clock
//     rst  synchronous, active-low reset
//     bus  pipe_ctrl_if.slave (all status inputs and control outputs)
//   Optional feature: define PIPE_CTRL_PERF_EN to build the saturating
//   stall/flush performance counters; otherwise both read as constant 0.
// -----------------------------------------------------------------------------
module pipe_ctrl (
  input  logic          clk,
  input  logic          rst,
  pipe_ctrl_if.slave    bus
);

  typedef struct packed {
    logic       wr_en;
    logic [4:0] wr_addr;
    logic       mem_rd;
  } shadow_t;

  localparam shadow_t SHADOW_CLR = '{wr_en: 1'b0, wr_addr: 5'd0, mem_rd: 1'b0};

  // True when a producer stage supplies register src. A load still in EX has
  // no result yet, so block_load excludes it (the load-use stall covers it).
  function automatic logic producer_hit(input shadow_t sh, input logic [4:0] src,
                                        input logic block_load);
    producer_hit = sh.wr_en && (sh.wr_addr == src) && !(block_load && sh.mem_rd);
  endfunction

  // Youngest matching producer wins; register zero is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src, input shadow_t ex_sh,
                                         input shadow_t mem_sh, input shadow_t wb_sh);
    logic [1:0] sel;
    sel = 2'b00;
    if (src == 5'd0) begin
      sel = 2'b00;
    end else if (producer_hit(ex_sh, src, 1'b1)) begin
      sel = 2'b01;
    end else if (producer_hit(mem_sh, src, 1'b0)) begin
      sel = 2'b10;
    end else if (producer_hit(wb_sh, src, 1'b0)) begin
      sel = 2'b11;
    end else begin
      sel = 2'b00;
    end
    fwd_sel = sel;
  endfunction

  shadow_t ex_sh_r;
  shadow_t mem_sh_r;
  shadow_t wb_sh_r;

  logic       load_use_s;
  logic [4:0] en_s;          // {pc, if, id, ex, mem}
  logic       if_flush_s;
  logic       id_flush_s;
  logic [1:0] fwd_a_s;
  logic [1:0] fwd_b_s;

  // Load in EX whose destination is read by the instruction in ID.
  always_comb begin
    load_use_s = 1'b0;
    if (ex_sh_r.mem_rd && ex_sh_r.wr_en && (ex_sh_r.wr_addr != 5'd0)) begin
      load_use_s = ((ex_sh_r.wr_addr == bus.id_rs) && bus.id_use_rs) ||
                   ((ex_sh_r.wr_addr == bus.id_rt) && bus.id_use_rt);
    end else begin
      load_use_s = 1'b0;
    end
  end

  // Stage enable / flush decision in priority order.
  always_comb begin
    en_s       = 5'b11111;
    if_flush_s = 1'b0;
    id_flush_s = 1'b0;
    if (!rst) begin
      en_s       = 5'b00000;
      if_flush_s = 1'b1;
      id_flush_s = 1'b1;
    end else if (bus.mem_busy) begin
      en_s       = 5'b00000;
      if_flush_s = 1'b0;
      id_flush_s = 1'b0;
    end else if (bus.ex_br_taken) begin
      en_s       = 5'b11111;
      if_flush_s = 1'b1;
      id_flush_s = 1'b1;
    end else if (load_use_s) begin
      en_s       = 5'b00011;
      if_flush_s = 1'b0;
      id_flush_s = 1'b1;
    end else begin
      en_s       = 5'b11111;
      if_flush_s = 1'b0;
      id_flush_s = 1'b0;
    end
  end

  // Operand forwarding selects, forced to the register file during reset.
  always_comb begin
    fwd_a_s = 2'b00;
    fwd_b_s = 2'b00;
    if (!rst) begin
      fwd_a_s = 2'b00;
      fwd_b_s = 2'b00;
    end else begin
      fwd_a_s = fwd_sel(bus.id_rs, ex_sh_r, mem_sh_r, wb_sh_r);
      fwd_b_s = fwd_sel(bus.id_rt, ex_sh_r, mem_sh_r, wb_sh_r);
    end
  end

  // Shadow pipeline: EX takes the ID instruction (or a bubble when ID/EX is
  // flushed); MEM and WB move together on the MEM enable.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_sh_r  <= SHADOW_CLR;
      mem_sh_r <= SHADOW_CLR;
      wb_sh_r  <= SHADOW_CLR;
    end else begin
      if (en_s[1]) begin
        if (id_flush_s) begin
          ex_sh_r <= SHADOW_CLR;
        end else begin
          ex_sh_r <= '{wr_en: bus.id_wr_en, wr_addr: bus.id_wr_addr, mem_rd: bus.id_mem_rd};
        end
      end
      if (en_s[0]) begin
        mem_sh_r <= ex_sh_r;
        wb_sh_r  <= mem_sh_r;
      end
    end
  end

  assign bus.pc_en    = en_s[4];
  assign bus.if_en    = en_s[3];
  assign bus.id_en    = en_s[2];
  assign bus.ex_en    = en_s[1];
  assign bus.mem_en   = en_s[0];
  assign bus.if_flush = if_flush_s;
  assign bus.id_flush = id_flush_s;
  assign bus.fwd_a    = fwd_a_s;
  assign bus.fwd_b    = fwd_b_s;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt_r;
  logic [31:0] flush_cnt_r;
  logic        stall_inc_s;
  logic        flush_inc_s;

  // A stall cycle is a freeze or a load-use stall that no branch cancelled.
  assign stall_inc_s = bus.mem_busy || (load_use_s && !bus.ex_br_taken);
  assign flush_inc_s = bus.ex_br_taken && !bus.mem_busy;

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_r <= 32'd0;
      flush_cnt_r <= 32'd0;
    end else begin
      if (stall_inc_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
        stall_cnt_r <= stall_cnt_r + 32'd1;
      end
      if (flush_inc_s && (flush_cnt_r != 32'hFFFF_FFFF)) begin
        flush_cnt_r <= flush_cnt_r + 32'd1;
      end
    end
  end

  assign bus.stall_cnt = stall_cnt_r;
  assign bus.flush_cnt = flush_cnt_r;
`else
  assign bus.stall_cnt = 32'd0;
  assign bus.flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl
//   Directed bench for pipe_ctrl. A small pipeline model (three producer slots
//   plus counters) predicts every output each cycle; directed scenarios add
//   hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

  logic clk;
  logic rst;
  logic next_rst;

  pipe_ctrl_if bus ();

  pipe_ctrl u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model: slot 0 = EX, 1 = MEM, 2 = WB ----------------
  logic       m_wen  [3];
  logic [4:0] m_addr [3];
  logic       m_mrd  [3];
  longint     m_stall;
  longint     m_flush;

  function automatic logic m_hazard();
    return m_mrd[0] && m_wen[0] && (m_addr[0] != 5'd0) &&
           (((m_addr[0] == bus.id_rs) && bus.id_use_rs) ||
            ((m_addr[0] == bus.id_rt) && bus.id_use_rt));
  endfunction

  function automatic logic [1:0] m_fwd(input logic [4:0] src);
    if (src == 5'd0) return 2'b00;
    for (int i = 0; i < 3; i++) begin
      if (m_wen[i] && (m_addr[i] == src) && !(i == 0 && m_mrd[i]))
        return 2'(i + 1);
    end
    return 2'b00;
  endfunction

  // Model state advance on the same edge as the DUT.
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        m_wen[i]  <= 1'b0;
        m_addr[i] <= 5'd0;
        m_mrd[i]  <= 1'b0;
      end
      m_stall <= 0;
      m_flush <= 0;
    end else begin
      if (!bus.mem_busy) begin
        m_wen[2]  <= m_wen[1];  m_addr[2] <= m_addr[1]; m_mrd[2] <= m_mrd[1];
        m_wen[1]  <= m_wen[0];  m_addr[1] <= m_addr[0]; m_mrd[1] <= m_mrd[0];
        if (bus.ex_br_taken || m_hazard()) begin
          m_wen[0] <= 1'b0; m_addr[0] <= 5'd0; m_mrd[0] <= 1'b0;
        end else begin
          m_wen[0] <= bus.id_wr_en; m_addr[0] <= bus.id_wr_addr; m_mrd[0] <= bus.id_mem_rd;
        end
      end
      if ((bus.mem_busy || (m_hazard() && !bus.ex_br_taken)) && m_stall < 64'hFFFF_FFFF)
        m_stall <= m_stall + 1;
      if (bus.ex_br_taken && !bus.mem_busy && m_flush < 64'hFFFF_FFFF)
        m_flush <= m_flush + 1;
    end
  end

  function automatic logic [31:0] exp_cnt(input longint v);
`ifdef PIPE_CTRL_PERF_EN
    return v[31:0];
`else
    return (v == 0) ? 32'd0 : 32'd0;
`endif
  endfunction

  // Per-cycle compare against the model, mid-cycle after inputs settle.
  always @(negedge clk) begin
    logic [4:0] e_en;
    logic [1:0] e_fl;
    logic [1:0] e_fa;
    logic [1:0] e_fb;
    #2;
    e_fa = 2'b00;
    e_fb = 2'b00;
    if (!rst) begin
      e_en = 5'b00000; e_fl = 2'b11;
    end else begin
      e_fa = m_fwd(bus.id_rs);
      e_fb = m_fwd(bus.id_rt);
      if (bus.mem_busy) begin
        e_en = 5'b00000; e_fl = 2'b00;
      end else if (bus.ex_br_taken) begin
        e_en = 5'b11111; e_fl = 2'b11;
      end else if (m_hazard()) begin
        e_en = 5'b00011; e_fl = 2'b01;
      end else begin
        e_en = 5'b11111; e_fl = 2'b00;
      end
    end
    chk("model_en", {27'd0, bus.pc_en, bus.if_en, bus.id_en, bus.ex_en, bus.mem_en}, {27'd0, e_en});
    chk("model_flush", {30'd0, bus.if_flush, bus.id_flush}, {30'd0, e_fl});
    chk("model_fwd_a", {30'd0, bus.fwd_a}, {30'd0, e_fa});
    chk("model_fwd_b", {30'd0, bus.fwd_b}, {30'd0, e_fb});
    chk("model_stall_cnt", bus.stall_cnt, exp_cnt(m_stall));
    chk("model_flush_cnt", bus.flush_cnt, exp_cnt(m_flush));
  end

  // Apply one cycle of ID/EX/MEM status at the falling edge.
  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                       input logic urt, input logic wen, input logic [4:0] waddr,
                       input logic mrd, input logic br, input logic busy);
    @(negedge clk);
    rst             = next_rst;
    bus.id_rs       = rs;
    bus.id_rt       = rt;
    bus.id_use_rs   = urs;
    bus.id_use_rt   = urt;
    bus.id_wr_en    = wen;
    bus.id_wr_addr  = waddr;
    bus.id_mem_rd   = mrd;
    bus.ex_br_taken = br;
    bus.mem_busy    = busy;
    #3;
  endtask

  task automatic nop();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic logic [31:0] en_vec();
    return {27'd0, bus.pc_en, bus.if_en, bus.id_en, bus.ex_en, bus.mem_en};
  endfunction

  localparam logic [31:0] PERF_ON =
`ifdef PIPE_CTRL_PERF_EN
    32'd1;
`else
    32'd0;
`endif

  initial begin
    rst = 1'b0; next_rst = 1'b0;
    bus.id_rs = 5'd0; bus.id_rt = 5'd0; bus.id_use_rs = 1'b0; bus.id_use_rt = 1'b0;
    bus.id_wr_en = 1'b0; bus.id_wr_addr = 5'd0; bus.id_mem_rd = 1'b0;
    bus.ex_br_taken = 1'b0; bus.mem_busy = 1'b0;

    // Reset state
    nop();
    chk("rst_en", en_vec(), 32'd0);
    chk("rst_flush", {30'd0, bus.if_flush, bus.id_flush}, 32'd3);
    chk("rst_fwd", {28'd0, bus.fwd_a, bus.fwd_b}, 32'd0);
    nop();
    next_rst = 1'b1;

    // Back-to-back load-use on r5 via rs
    drive(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    chk("normal_en", en_vec(), 32'h1F);
    drive(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0);
    chk("lu_pc_en", {31'd0, bus.pc_en}, 32'd0);
    chk("lu_id_flush", {31'd0, bus.id_flush}, 32'd1);
    chk("lu_en", en_vec(), 32'h03);
    drive(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0);
    chk("lu_next_fwd_a", {30'd0, bus.fwd_a}, 32'd2);
    chk("lu_next_pc_en", {31'd0, bus.pc_en}, 32'd1);
    nop();

    // Forwarding priority on r3 via rt
    repeat (3) drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0);
    drive(5'd0, 5'd3, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("fwd_b_ex", {30'd0, bus.fwd_b}, 32'd1);
    drive(5'd0, 5'd3, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("fwd_b_mem", {30'd0, bus.fwd_b}, 32'd2);
    drive(5'd0, 5'd3, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("fwd_b_wb", {30'd0, bus.fwd_b}, 32'd3);

    // Register zero: load to r0 never stalls nor forwards
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
    drive(5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0);
    chk("r0_fwd_a", {30'd0, bus.fwd_a}, 32'd0);
    chk("r0_en", en_vec(), 32'h1F);

    // Freeze for 3 cycles over a load-use on r7, then one stall
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      drive(5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b1);
      chk("freeze_en", en_vec(), 32'd0);
      chk("freeze_flush", {30'd0, bus.if_flush, bus.id_flush}, 32'd0);
    end
    drive(5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
    chk("post_freeze_stall", en_vec(), 32'h03);
    drive(5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
    chk("post_freeze_fwd_a", {30'd0, bus.fwd_a}, 32'd2);
    chk("stall_cnt_5", bus.stall_cnt, PERF_ON * 32'd5);
    nop();

    // Branch taken together with a load-use on r8
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
    drive(5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 5'd10, 1'b0, 1'b1, 1'b0);
    chk("br_flush", {30'd0, bus.if_flush, bus.id_flush}, 32'd3);
    chk("br_en", en_vec(), 32'h1F);
    nop();
    chk("flush_cnt_1", bus.flush_cnt, PERF_ON * 32'd1);
    chk("stall_cnt_still_5", bus.stall_cnt, PERF_ON * 32'd5);

    // Reset pulse during a freeze
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    drive(5'd9, 5'd9, 1'b1, 1'b1, 1'b1, 5'd11, 1'b0, 1'b0, 1'b1);
    chk("pre_rst_freeze_en", en_vec(), 32'd0);
    next_rst = 1'b0;
    drive(5'd9, 5'd9, 1'b1, 1'b1, 1'b1, 5'd11, 1'b0, 1'b0, 1'b1);
    chk("mid_rst_flush", {30'd0, bus.if_flush, bus.id_flush}, 32'd3);
    chk("mid_rst_en", en_vec(), 32'd0);
    next_rst = 1'b1;
    drive(5'd9, 5'd9, 1'b1, 1'b1, 1'b1, 5'd11, 1'b0, 1'b0, 1'b0);
    chk("after_rst_en", en_vec(), 32'h1F);
    chk("after_rst_fwd", {28'd0, bus.fwd_a, bus.fwd_b}, 32'd0);
    chk("after_rst_stall_cnt", bus.stall_cnt, 32'd0);
    nop();

    @(negedge clk);
    #4;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
